// File: rtl/serial_bridge_pkg.sv
// Shared types and frame geometry for the Avalon-MM to serial-link bridge.
package serial_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_OUT,
        ST_WAIT_RDY,
        ST_SHIFT_IN,
        ST_WAIT_DONE,
        ST_COMPLETE,
        ST_ERROR
    } state_e;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    // Frame is {cmd, byteenable, address, data}, data field at the LSB end.
    function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
        return 1 + data_w / 8 + addr_w + data_w;
    endfunction

    function automatic int unsigned data_lsb();
        return 0;
    endfunction

    function automatic int unsigned addr_lsb(input int unsigned data_w);
        return data_w;
    endfunction

    function automatic int unsigned be_lsb(input int unsigned addr_w, input int unsigned data_w);
        return data_w + addr_w;
    endfunction

    function automatic int unsigned cmd_pos(input int unsigned addr_w, input int unsigned data_w);
        return data_w + addr_w + data_w / 8;
    endfunction

endpackage

// File: rtl/serial_shifter.sv
// Shared shift register: parallel load, MSB-first shift-out, LSB shift-in, with bit counter.
module serial_shifter #(
    parameter int unsigned W     = 8,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [W-1:0]     load_val_i,
    input  logic             shift_i,
    input  logic             clr_i,
    input  logic             sdi_i,
    input  logic [CNT_W-1:0] len_i,
    output logic [OUT_W-1:0] data_o,
    output logic             msb_o,
    output logic             done_c_o
);

    logic [W-1:0]     shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load wins over shift; clr restarts the count on the shift that ends a phase.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shreg_d = load_val_i;
            cnt_d   = '0;
        end else if (shift_i) begin
            shreg_d = {shreg_q[W-2:0], sdi_i};
            cnt_d   = clr_i ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Shift register and bit counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_o   = shreg_q[OUT_W-1:0];
    assign msb_o    = shreg_q[W-1];
    assign done_c_o = (cnt_q == len_i - CNT_W'(1));

endmodule

// File: rtl/qsys_serial_bridge_v2.sv
// Avalon-MM slave to framed serial-link bridge with ready timeout.
// Optional even parity on both directions: define SERIAL_BRIDGE_PARITY_EN.
module qsys_serial_bridge_v2
    import serial_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned TIMEOUT  = 1024,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                csi_MCLK_clk,
    input  logic                rsi_MRST_reset_n,
    input  logic [ADDR_W-1:0]   avs_ctrl_address,
    input  logic [DATA_W-1:0]   avs_ctrl_writedata,
    input  logic [DATA_W/8-1:0] avs_ctrl_byteenable,
    input  logic                avs_ctrl_write,
    input  logic                avs_ctrl_read,
    output logic [DATA_W-1:0]   avs_ctrl_readdata,
    output logic                avs_ctrl_waitrequest,
    output logic                sdo,
    input  logic                sdi,
    output logic                clk,
    output logic                sle,
    input  logic                srdy,
    output logic                err_timeout
`ifdef SERIAL_BRIDGE_PARITY_EN
    ,
    output logic                err_parity
`endif
);

    localparam int unsigned BE_W     = DATA_W / 8;
    localparam int unsigned FRAME_W  = frame_w(ADDR_W, DATA_W);
    localparam int unsigned DATA_LSB = data_lsb();
    localparam int unsigned ADDR_LSB = addr_lsb(DATA_W);
    localparam int unsigned BE_LSB   = be_lsb(ADDR_W, DATA_W);
    localparam int unsigned CMD_POS  = cmd_pos(ADDR_W, DATA_W);
`ifdef SERIAL_BRIDGE_PARITY_EN
    localparam int unsigned TX_W     = FRAME_W + 1;
    localparam int unsigned RX_W     = DATA_W + 1;
`else
    localparam int unsigned TX_W     = FRAME_W;
    localparam int unsigned RX_W     = DATA_W;
`endif
    localparam int unsigned CNT_W    = $clog2(TX_W + 1);
    localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    logic                is_wr_q, is_wr_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d, tmo_inc_c;
    logic                tmo_exp_c;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                wreq_q, wreq_d;
    logic                sle_q, sle_d;
    logic                err_tmo_q, err_tmo_d;

    logic [FRAME_W-1:0]  frame_c;
    logic [TX_W-1:0]     load_val_c;
    logic [RX_W-1:0]     sh_data;
    logic [DATA_W-1:0]   rx_word_c;
    logic                par_ok_c;
    logic                sh_msb, sh_done_c;
    logic                sh_load_c, sh_shift_c, sh_clr_c, sh_sdi_c;
    logic [CNT_W-1:0]    sh_len_c;

    // Frame assembled straight from the bus; only loaded while idle.
    always_comb begin
        frame_c                     = '0;
        frame_c[CMD_POS]            = avs_ctrl_write ? CMD_WRITE : CMD_READ;
        frame_c[BE_LSB +: BE_W]     = avs_ctrl_byteenable;
        frame_c[ADDR_LSB +: ADDR_W] = avs_ctrl_address;
        if (avs_ctrl_write) begin
            frame_c[DATA_LSB +: DATA_W] = avs_ctrl_writedata;
        end
    end

`ifdef SERIAL_BRIDGE_PARITY_EN
    assign load_val_c = {frame_c, ^frame_c};
    assign rx_word_c  = sh_data[DATA_W:1];
    assign par_ok_c   = ~^sh_data;
`else
    assign load_val_c = frame_c;
    assign rx_word_c  = sh_data;
    assign par_ok_c   = 1'b1;
`endif

    assign sh_len_c  = (state_q == ST_SHIFT_OUT) ? CNT_W'(TX_W) : CNT_W'(RX_W);
    assign tmo_exp_c = (tmo_q == TMO_W'(TIMEOUT - 1));
    assign tmo_inc_c = (tmo_q == TMO_W'(TIMEOUT)) ? tmo_q : tmo_q + TMO_W'(1);

    serial_shifter #(
        .W     (TX_W),
        .OUT_W (RX_W),
        .CNT_W (CNT_W)
    ) u_shifter (
        .clk_i      (csi_MCLK_clk),
        .rst_ni     (rsi_MRST_reset_n),
        .load_i     (sh_load_c),
        .load_val_i (load_val_c),
        .shift_i    (sh_shift_c),
        .clr_i      (sh_clr_c),
        .sdi_i      (sh_sdi_c),
        .len_i      (sh_len_c),
        .data_o     (sh_data),
        .msb_o      (sh_msb),
        .done_c_o   (sh_done_c)
    );

    // Next-state, shifter control and next values of the registered bus outputs.
    always_comb begin
        state_d    = state_q;
        is_wr_d    = is_wr_q;
        tmo_d      = tmo_q;
        rdata_d    = rdata_q;
        err_tmo_d  = err_tmo_q;
        sh_load_c  = 1'b0;
        sh_shift_c = 1'b0;
        sh_clr_c   = 1'b0;
        sh_sdi_c   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (avs_ctrl_write || avs_ctrl_read) begin
                    is_wr_d   = avs_ctrl_write;
                    sh_load_c = 1'b1;
                    state_d   = ST_SHIFT_OUT;
                end
            end
            ST_SHIFT_OUT: begin
                sh_shift_c = 1'b1;
                if (sh_done_c) begin
                    sh_clr_c = 1'b1;
                    tmo_d    = '0;
                    state_d  = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                if (srdy) begin
                    sh_shift_c = 1'b1;
                    sh_sdi_c   = sdi;
                    state_d    = ST_SHIFT_IN;
                end else if (tmo_exp_c) begin
                    err_tmo_d = 1'b1;
                    state_d   = ST_ERROR;
                end else begin
                    tmo_d = tmo_inc_c;
                end
            end
            ST_SHIFT_IN: begin
                sh_shift_c = 1'b1;
                sh_sdi_c   = sdi;
                if (sh_done_c) begin
                    tmo_d   = '0;
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!srdy) begin
                    state_d = par_ok_c ? ST_COMPLETE : ST_ERROR;
                end else if (tmo_exp_c) begin
                    err_tmo_d = 1'b1;
                    state_d   = ST_ERROR;
                end else begin
                    tmo_d = tmo_inc_c;
                end
            end
            ST_COMPLETE, ST_ERROR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_COMPLETE) begin
            err_tmo_d = 1'b0;
            if (!is_wr_q) begin
                rdata_d = rx_word_c;
            end
        end
        if ((state_d == ST_ERROR) && !is_wr_q) begin
            rdata_d = DATA_W'(ERR_DATA);
        end
        wreq_d = !((state_d == ST_COMPLETE) || (state_d == ST_ERROR));
        sle_d  = (state_d == ST_SHIFT_OUT);
    end

    // State and registered outputs.
    always_ff @(posedge csi_MCLK_clk) begin
        if (!rsi_MRST_reset_n) begin
            state_q   <= ST_IDLE;
            is_wr_q   <= 1'b0;
            tmo_q     <= '0;
            rdata_q   <= '0;
            wreq_q    <= 1'b1;
            sle_q     <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_wr_q   <= is_wr_d;
            tmo_q     <= tmo_d;
            rdata_q   <= rdata_d;
            wreq_q    <= wreq_d;
            sle_q     <= sle_d;
            err_tmo_q <= err_tmo_d;
        end
    end

`ifdef SERIAL_BRIDGE_PARITY_EN
    logic err_par_q, err_par_d;

    // Sticky parity flag: set on a bad response, cleared by a good transaction.
    always_comb begin
        err_par_d = err_par_q;
        if ((state_q == ST_WAIT_DONE) && !srdy && !par_ok_c) begin
            err_par_d = 1'b1;
        end else if (state_d == ST_COMPLETE) begin
            err_par_d = 1'b0;
        end
    end

    // Parity flag register.
    always_ff @(posedge csi_MCLK_clk) begin
        if (!rsi_MRST_reset_n) begin
            err_par_q <= 1'b0;
        end else begin
            err_par_q <= err_par_d;
        end
    end

    assign err_parity = err_par_q;
`endif

    // Shift register MSB is zero outside the outgoing frame, so sdo idles low.
    assign sdo                  = sh_msb;
    assign sle                  = sle_q;
    assign clk                  = csi_MCLK_clk;
    assign avs_ctrl_readdata    = rdata_q;
    assign avs_ctrl_waitrequest = wreq_q;
    assign err_timeout          = err_tmo_q;

endmodule

// File: doc/qsys_serial_bridge_v2.md
Name: qsys_serial_bridge_v2

Overview:
- Parametrised next-generation Avalon-MM slave to serial-link bridge.
- Serialises each bus read/write into a framed bit stream (cmd + address + data) on sdo, framed by sle.
- Waits for the remote device's srdy handshake, shifts the response in from sdi, then completes the bus cycle with a real waitrequest.
- Adds a ready timeout with error reporting. Sits between the Qsys interconnect and off-chip/peripheral serial devices.

Parameters:
- ADDR_W, 8: Avalon address width (bits serialised).
- DATA_W, 32: Avalon data width and response width.
- TIMEOUT, 1024: max cycles spent in WAIT_RDY or WAIT_DONE before abort; must be ≥2.
- ERR_DATA, 32'hDEAD_BEEF: readdata returned on timeout (truncated/zero-extended to DATA_W).

Ports:
- csi_MCLK_clk  in  1  sole clock; sdo/sle/sdi/srdy are synchronous to it.
- rsi_MRST_reset_n  in  1  synchronous, active-low reset.
- avs_ctrl_address  in  ADDR_W  word address.
- avs_ctrl_writedata  in  DATA_W  write data.
- avs_ctrl_byteenable  in  DATA_W/8  serialised in frame.
- avs_ctrl_write  in  1  write request.
- avs_ctrl_read  in  1  read request.
- avs_ctrl_readdata  out  DATA_W  response data.
- avs_ctrl_waitrequest  out  1  stall.
- sdo  out  1  serial data out, MSB first.
- sdi  in  1  serial data in, MSB first.
- clk  out  1  = csi_MCLK_clk (forwarded).
- sle  out  1  frame enable, high exactly while frame bits are on sdo.
- srdy  in  1  device ready/response-valid.
- err_timeout  out  1  sticky, set on timeout, cleared by a successful transaction.

Behaviour:
- Frame layout: FRAME_W = 1 + DATA_W/8 + ADDR_W + DATA_W. Fields in order: cmd (1=write, 0=read), byteenable, address, data (writedata for writes, zeros for reads). Sent MSB first.
- Reset values: sdo=0, sle=0, waitrequest=1, readdata=0, err_timeout=0, state=IDLE. Reset mid-transaction aborts immediately; the pending bus request is not completed.
- States and transitions:
  - IDLE: if read or write is high, latch the frame and go to SHIFT_OUT. If both are high, write wins.
  - SHIFT_OUT: FRAME_W cycles, one bit per cycle. sle=1 and sdo valid on each of those cycles. Bit counter is $clog2(FRAME_W+1) wide. Then go to WAIT_RDY.
  - WAIT_RDY: wait for srdy=1, then go to SHIFT_IN. If TIMEOUT cycles elapse, go to ERROR.
  - SHIFT_IN: sample sdi on DATA_W consecutive cycles; the first sample is the cycle srdy is first seen high. Then go to WAIT_DONE. srdy dropping during SHIFT_IN is ignored.
  - WAIT_DONE: wait for srdy=0, then go to COMPLETE. On timeout go to ERROR.
  - COMPLETE: readdata = shifted-in word (reads only; writes leave readdata unchanged). waitrequest=0 for exactly this one cycle. Clear err_timeout. Return to IDLE.
  - ERROR: readdata = ERR_DATA for reads. err_timeout=1. waitrequest=0 for one cycle. Return to IDLE.
- waitrequest: registered, =0 only in COMPLETE/ERROR, else 1. The master must hold read/write/address/data until waitrequest=0. Request values are captured in IDLE only.
- Latency for a read with srdy responding immediately: FRAME_W + 1 + DATA_W + 2 cycles from request to waitrequest low.
- Timeout counter resets on every entry to WAIT_RDY/WAIT_DONE; saturating, no wrap.
- sdo=0 whenever sle=0.
- srdy already high on entry to WAIT_RDY counts immediately.

Optional Feature:
- SERIAL_BRIDGE_PARITY_EN: defined → one even-parity bit appended after the frame LSB (FRAME_W+1 bits, sle covers it). One parity bit is expected on sdi after the DATA_W response bits. Parity mismatch takes the ERROR path (readdata=ERR_DATA, err_timeout stays as-is), and a separate sticky err_parity output port is added.
- Undefined → no parity bit, no err_parity port.

Decomposition:
- Package serial_bridge_pkg: state enum, frame field offset functions of ADDR_W/DATA_W, cmd encodings CMD_READ=0 and CMD_WRITE=1.
- One sub-module serial_shifter: parametrised width, load/shift-out/shift-in, with bit counter and done flag.

Test Plan (ADDR_W=8, DATA_W=32):
- Write addr 8'h12, data 32'hA5A5_0F0F, be 4'hF; device raises srdy after 3 cycles → sle high 45 cycles; sdo pattern = 1,1111,00010010,A5A50F0F bits; waitrequest low one cycle after srdy drop; err_timeout=0.
- Read addr 8'h34; device returns 32'h1234_5678 on sdi → readdata=32'h1234_5678 in the waitrequest-low cycle.
- Read with srdy never asserted, TIMEOUT=16 → waitrequest low after frame + 16 cycles; readdata=32'hDEAD_BEEF; err_timeout=1; a following good read clears it.
- read and write asserted together → frame cmd bit=1 (write).
- Reset pulled low mid-SHIFT_OUT (bit 20) → next cycle sle=0, sdo=0, waitrequest=1; a new request completes normally.
- Back-to-back reads with srdy held high → second frame starts only after srdy drops; no overlap of sle with the response.
